// File: rtl/proj_pkg.sv
// Shared definitions for the projection sweep controller: state encoding,
// MISR polynomial/seed and the default input width.
package proj_pkg;

  localparam int          N_IN_DEFAULT = 14;
  localparam logic [15:0] MISR_POLY    = 16'h1021;
  localparam logic [15:0] MISR_SEED    = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sweep_state_e;

endpackage

// File: rtl/proj_scatter.sv
// Deposits the low counter bits, in ascending order, into the free (mask=0)
// positions of the vector; fixed positions take their value from val.
module proj_scatter #(
  parameter int N_IN = 14
) (
  input  logic [N_IN-1:0] mask,
  input  logic [N_IN-1:0] val,
  input  logic [N_IN-1:0] cnt,
  output logic [N_IN-1:0] x
);

  localparam int KW = (N_IN > 1) ? $clog2(N_IN + 1) : 1;

  logic [KW-1:0] k;

  always_comb begin
    x = val & mask;
    k = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (!mask[i]) begin
        x[i] = cnt[k];
        k    = k + KW'(1);
      end
    end
  end

endmodule

// File: rtl/proj_sweep_ctrl.sv
// Exhaustive sweep sequencer for a projected single-output function:
// enumerates all free-variable assignments, counts the onset and builds a MISR.
module proj_sweep_ctrl
  import proj_pkg::*;
#(
  parameter int  N_IN  = N_IN_DEFAULT,
  parameter int  LAT   = 0,
  parameter int  SIG_W = 16,
  localparam int FW    = $clog2(N_IN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [N_IN-1:0]  fix_mask,
  input  logic [N_IN-1:0]  fix_val,
  output logic [N_IN-1:0]  x,
  output logic             x_valid,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic [N_IN:0]    onset_cnt,
  output logic [SIG_W-1:0] sig,
  output logic [FW-1:0]    n_free
);

  localparam int            DW         = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'((LAT > 0) ? LAT - 1 : 0);

  sweep_state_e     state_reg;
  logic [N_IN-1:0]  mask_reg, val_reg, cnt_reg, last_reg, x_reg;
  logic             x_valid_reg, done_reg;
  logic [N_IN:0]    onset_reg;
  logic [SIG_W-1:0] sig_reg;
  logic [FW-1:0]    n_free_reg;
  logic [DW-1:0]    drain_reg;

  logic [FW-1:0]    free_cnt;
  logic [N_IN-1:0]  last_next;
  logic [N_IN-1:0]  sc_mask, sc_val, sc_cnt, sc_x;
  logic             start_go, kill, samp_valid;
  logic [LAT:0]     vchain;

  assign start_go = (state_reg == IDLE) && start;
  assign kill     = abort && ((state_reg == SWEEP) || (state_reg == DRAIN));

  always_comb begin
    free_cnt = '0;
    for (int i = 0; i < N_IN; i++) begin
      free_cnt = free_cnt + FW'(!fix_mask[i]);
    end
  end

  assign last_next = ~({N_IN{1'b1}} << free_cnt);

  // In IDLE the scatter sees the live inputs so vector 0 is ready at the start edge.
  assign sc_mask = (state_reg == IDLE) ? fix_mask : mask_reg;
  assign sc_val  = (state_reg == IDLE) ? fix_val  : val_reg;
  assign sc_cnt  = (state_reg == IDLE) ? '0 : cnt_reg + N_IN'(1);

  proj_scatter #(.N_IN(N_IN)) u_scatter (
    .mask (sc_mask),
    .val  (sc_val),
    .cnt  (sc_cnt),
    .x    (sc_x)
  );

  assign vchain[0] = x_valid_reg;

  genvar gi;
  generate
    for (gi = 0; gi < LAT; gi++) begin : g_vpipe
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vchain[gi+1] <= 1'b0;
        end else begin
          vchain[gi+1] <= kill ? 1'b0 : vchain[gi];
        end
      end
    end
  endgenerate

  assign samp_valid = vchain[LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      mask_reg    <= '0;
      val_reg     <= '0;
      cnt_reg     <= '0;
      last_reg    <= '0;
      x_reg       <= '0;
      x_valid_reg <= 1'b0;
      done_reg    <= 1'b0;
      n_free_reg  <= '0;
      drain_reg   <= '0;
    end else begin
      done_reg <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          if (start) begin
            mask_reg    <= fix_mask;
            val_reg     <= fix_val;
            cnt_reg     <= '0;
            last_reg    <= last_next;
            n_free_reg  <= free_cnt;
            x_reg       <= sc_x;
            x_valid_reg <= 1'b1;
            state_reg   <= SWEEP;
          end
        end
        SWEEP: begin
          if (abort) begin
            x_valid_reg <= 1'b0;
            state_reg   <= IDLE;
          end else if (cnt_reg == last_reg) begin
            x_valid_reg <= 1'b0;
            if (LAT == 0) begin
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end else begin
              drain_reg <= DRAIN_LOAD;
              state_reg <= DRAIN;
            end
          end else begin
            cnt_reg <= cnt_reg + N_IN'(1);
            x_reg   <= sc_x;
          end
        end
        DRAIN: begin
          if (abort) begin
            state_reg <= IDLE;
          end else if (drain_reg == '0) begin
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else begin
            drain_reg <= drain_reg - DW'(1);
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // A sample arriving on the abort edge is dropped: results freeze as they stood.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      onset_reg <= '0;
      sig_reg   <= SIG_W'(MISR_SEED);
    end else if (start_go) begin
      onset_reg <= '0;
      sig_reg   <= SIG_W'(MISR_SEED);
    end else if (samp_valid && !kill) begin
      onset_reg <= onset_reg + (N_IN+1)'(y);
      sig_reg   <= {sig_reg[SIG_W-2:0], 1'b0} ^
                   ((sig_reg[SIG_W-1] ^ y) ? SIG_W'(MISR_POLY) : '0);
    end
  end

  assign x         = x_reg;
  assign x_valid   = x_valid_reg;
  assign busy      = (state_reg == SWEEP) || (state_reg == DRAIN);
  assign done      = done_reg;
  assign onset_cnt = onset_reg;
  assign sig       = sig_reg;
  assign n_free    = n_free_reg;

endmodule

// File: tb/tb_proj_sweep_ctrl.sv
// Bench for proj_sweep_ctrl: a LAT=0 and a LAT=3 instance driven by functions
// of x, checked against a vector-by-vector reference sweep.
module tb_proj_sweep_ctrl;

  logic        clk, rst;
  logic        start0, start3, abort;
  logic [13:0] fix_mask, fix_val;
  logic [13:0] x0, x3;
  logic        x_valid0, x_valid3, y0, y3;
  logic        busy0, busy3, done0, done3;
  logic [14:0] onset0, onset3;
  logic [15:0] sig0, sig3;
  logic [3:0]  nfree0, nfree3;

  int          fsel;
  logic [13:0] key_a, key_b;
  logic        d1, d2, d3;
  int          n_checks, n_pass;

  proj_sweep_ctrl #(.N_IN(14), .LAT(0), .SIG_W(16)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort),
    .fix_mask(fix_mask), .fix_val(fix_val), .x(x0), .x_valid(x_valid0),
    .y(y0), .busy(busy0), .done(done0), .onset_cnt(onset0), .sig(sig0),
    .n_free(nfree0)
  );

  proj_sweep_ctrl #(.N_IN(14), .LAT(3), .SIG_W(16)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .abort(abort),
    .fix_mask(fix_mask), .fix_val(fix_val), .x(x3), .x_valid(x_valid3),
    .y(y3), .busy(busy3), .done(done3), .onset_cnt(onset3), .sig(sig3),
    .n_free(nfree3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic model_f(input int fs, input logic [13:0] v,
                                   input logic [13:0] ka, input logic [13:0] kb);
    case (fs)
      0:       return ^v;
      1:       return v[9];
      2:       return v[0] & v[1];
      default: return (^(v & ka)) ^ ((v & kb) == kb);
    endcase
  endfunction

  assign y0 = model_f(fsel, x0, key_a, key_b);

  // Three-cycle pipelined version of the same function for the LAT=3 instance.
  always @(posedge clk) begin
    d1 <= model_f(fsel, x3, key_a, key_b);
    d2 <= d1;
    d3 <= d2;
  end
  assign y3 = d3;

  // Vector number n of a sweep: n's bits go, lowest first, to the free positions.
  function automatic logic [13:0] m_scatter(input logic [13:0] mask,
                                            input logic [13:0] val, input int n);
    logic [13:0] r;
    int          j;
    r = val & mask;
    j = 0;
    for (int i = 0; i < 14; i++) begin
      if (!mask[i]) begin
        r[i] = n[j];
        j++;
      end
    end
    return r;
  endfunction

  task automatic model_run(input logic [13:0] mask, input logic [13:0] val,
                           input int fs, input int nvec,
                           output int on, output logic [15:0] s);
    logic yb;
    on = 0;
    s  = 16'hFFFF;
    for (int k = 0; k < nvec; k++) begin
      yb = model_f(fs, m_scatter(mask, val, k), key_a, key_b);
      on = on + int'(yb);
      s  = {s[14:0], 1'b0} ^ ((s[15] ^ yb) ? 16'h1021 : 16'h0000);
    end
  endtask

  function automatic logic g_xv(input bit s);          return s ? x_valid3 : x_valid0; endfunction
  function automatic logic [13:0] g_x(input bit s);    return s ? x3 : x0;             endfunction
  function automatic logic g_busy(input bit s);        return s ? busy3 : busy0;       endfunction
  function automatic logic g_done(input bit s);        return s ? done3 : done0;       endfunction
  function automatic logic [14:0] g_onset(input bit s); return s ? onset3 : onset0;    endfunction
  function automatic logic [15:0] g_sig(input bit s);  return s ? sig3 : sig0;         endfunction
  function automatic logic [3:0] g_nfree(input bit s); return s ? nfree3 : nfree0;     endfunction

  task automatic do_sweep(input bit use3, input logic [13:0] mask, input logic [13:0] val,
                          input int fs, input bit with_abort, input bit leave_in_done,
                          input string name);
    int          f, nv, lat, c, nvalid, xerr, done_c, busy_n, exp_on;
    logic [15:0] exp_sig;
    logic        bz_at_done;
    lat = use3 ? 3 : 0;
    f   = $countones(~mask);
    nv  = 1 << f;
    fsel = fs; fix_mask = mask; fix_val = val; abort = with_abort;
    if (use3) start3 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start3 = 1'b0; abort = 1'b0;
    c = 1; nvalid = 0; xerr = 0; done_c = -1; busy_n = 0; bz_at_done = 1'bx;
    while (c <= nv + lat + 8) begin
      if (g_xv(use3)) begin
        if (g_x(use3) !== m_scatter(mask, val, nvalid)) xerr++;
        nvalid++;
      end
      if (g_busy(use3)) busy_n++;
      if (g_done(use3)) begin
        done_c = c;
        bz_at_done = g_busy(use3);
        break;
      end
      @(posedge clk); #1;
      c++;
    end
    model_run(mask, val, fs, nv, exp_on, exp_sig);
    $display("sweep %s: F=%0d LAT=%0d vectors=%0d onset=%0d sig=%h done@k+%0d",
             name, f, lat, nvalid, g_onset(use3), g_sig(use3), done_c);

    n_checks++;
    if (nvalid != nv) $display("FAIL %s nvec: got %0d want %0d", name, nvalid, nv);
    else n_pass++;
    n_checks++;
    if (xerr != 0) $display("FAIL %s x_seq: got %0d bad vectors want 0", name, xerr);
    else n_pass++;
    n_checks++;
    if (done_c != nv + lat + 1) $display("FAIL %s done_cycle: got k+%0d want k+%0d", name, done_c, nv + lat + 1);
    else n_pass++;
    n_checks++;
    if (busy_n != nv + lat) $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_n, nv + lat);
    else n_pass++;
    n_checks++;
    if (bz_at_done !== 1'b0) $display("FAIL %s busy_in_done: got %b want 0", name, bz_at_done);
    else n_pass++;
    n_checks++;
    if (g_onset(use3) !== 15'(exp_on)) $display("FAIL %s onset: got %0d want %0d", name, g_onset(use3), exp_on);
    else n_pass++;
    n_checks++;
    if (g_sig(use3) !== exp_sig) $display("FAIL %s sig: got %h want %h", name, g_sig(use3), exp_sig);
    else n_pass++;
    n_checks++;
    if (g_nfree(use3) !== 4'(f)) $display("FAIL %s n_free: got %0d want %0d", name, g_nfree(use3), f);
    else n_pass++;

    if (!leave_in_done) begin
      @(posedge clk); #1;
      n_checks++;
      if (g_done(use3) !== 1'b0 || g_onset(use3) !== 15'(exp_on) || g_sig(use3) !== exp_sig)
        $display("FAIL %s hold_after_done: got done=%b onset=%0d sig=%h want done=0 onset=%0d sig=%h",
                 name, g_done(use3), g_onset(use3), g_sig(use3), exp_on, exp_sig);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start0 = 1'b0; start3 = 1'b0; abort = 1'b0;
    fix_mask = '0; fix_val = '0; fsel = 0; key_a = '0; key_b = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({x0, x_valid0, busy0, done0, onset0, sig0, nfree0} !== {14'h0, 3'b000, 15'h0, 16'hFFFF, 4'h0})
      $display("FAIL reset_dut0: got x=%h xv=%b busy=%b done=%b onset=%0d sig=%h nfree=%0d want 0/0/0/0/0/ffff/0",
               x0, x_valid0, busy0, done0, onset0, sig0, nfree0);
    else n_pass++;
    n_checks++;
    if ({x3, x_valid3, busy3, done3, onset3, sig3, nfree3} !== {14'h0, 3'b000, 15'h0, 16'hFFFF, 4'h0})
      $display("FAIL reset_dut3: got x=%h xv=%b busy=%b done=%b onset=%0d sig=%h nfree=%0d want 0/0/0/0/0/ffff/0",
               x3, x_valid3, busy3, done3, onset3, sig3, nfree3);
    else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (busy0 !== 1'b0 || x_valid0 !== 1'b0) $display("FAIL idle_after_reset: got busy=%b xv=%b want 0 0", busy0, x_valid0);
    else n_pass++;
    $display("reset: outputs checked on both instances");
  endtask

  task automatic test_full_xor();
    do_sweep(1'b0, 14'h0000, 14'h0000, 0, 1'b0, 1'b0, "full_xor");
    n_checks++;
    if (onset0 !== 15'd8192) $display("FAIL full_xor_onset_const: got %0d want 8192", onset0);
    else n_pass++;
  endtask

  task automatic test_all_fixed();
    do_sweep(1'b0, 14'h3FFF, 14'h0200, 1, 1'b0, 1'b0, "all_fixed");
    n_checks++;
    if (onset0 !== 15'd1) $display("FAIL all_fixed_onset_const: got %0d want 1", onset0);
    else n_pass++;
  endtask

  task automatic test_lat3();
    do_sweep(1'b1, 14'h3C00, 14'($urandom), 2, 1'b0, 1'b0, "lat3_and");
    n_checks++;
    if (onset3 !== 15'd256) $display("FAIL lat3_onset_const: got %0d want 256", onset3);
    else n_pass++;
  endtask

  task automatic test_abort();
    int          xerr, exp_on, saw_done;
    logic [15:0] exp_sig;
    fsel = 0; fix_mask = 14'h0000; fix_val = 14'h0000; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    xerr = 0;
    for (int c = 1; c < 100; c++) begin
      if (x_valid0 !== 1'b1 || x0 !== m_scatter(14'h0000, 14'h0000, c - 1)) xerr++;
      if (c == 50) begin
        start0 = 1'b1; fix_mask = 14'h3FFF;
      end else begin
        start0 = 1'b0;
      end
      @(posedge clk); #1;
    end
    start0 = 1'b0; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_checks++;
    if (busy0 !== 1'b0 || x_valid0 !== 1'b0) $display("FAIL abort_to_idle: got busy=%b xv=%b want 0 0", busy0, x_valid0);
    else n_pass++;
    saw_done = 0;
    for (int c = 0; c < 4; c++) begin
      if (done0 === 1'b1) saw_done++;
      @(posedge clk); #1;
    end
    model_run(14'h0000, 14'h0000, 0, 99, exp_on, exp_sig);
    $display("abort: partial onset=%0d sig=%h", onset0, sig0);
    n_checks++;
    if (xerr != 0) $display("FAIL abort_x_seq: got %0d bad vectors want 0", xerr);
    else n_pass++;
    n_checks++;
    if (saw_done != 0) $display("FAIL abort_no_done: got %0d done pulses want 0", saw_done);
    else n_pass++;
    n_checks++;
    if (onset0 !== 15'(exp_on)) $display("FAIL abort_onset: got %0d want %0d", onset0, exp_on);
    else n_pass++;
    n_checks++;
    if (sig0 !== exp_sig) $display("FAIL abort_sig: got %h want %h", sig0, exp_sig);
    else n_pass++;
  endtask

  task automatic test_reset_mid_drain();
    fsel = 2; fix_mask = 14'h3C00; fix_val = 14'($urandom); start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    repeat (1025) @(posedge clk);
    #1;
    n_checks++;
    if (busy3 !== 1'b1 || x_valid3 !== 1'b0) $display("FAIL in_drain: got busy=%b xv=%b want 1 0", busy3, x_valid3);
    else n_pass++;
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if ({x3, x_valid3, busy3, done3, onset3, sig3, nfree3} !== {14'h0, 3'b000, 15'h0, 16'hFFFF, 4'h0})
      $display("FAIL async_reset_dut3: got x=%h xv=%b busy=%b done=%b onset=%0d sig=%h nfree=%0d want 0/0/0/0/0/ffff/0",
               x3, x_valid3, busy3, done3, onset3, sig3, nfree3);
    else n_pass++;
    #1 rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (busy3 !== 1'b0 || done3 !== 1'b0) $display("FAIL no_resume: got busy=%b done=%b want 0 0", busy3, done3);
    else n_pass++;
    $display("reset mid-drain: dut3 back to idle");
    do_sweep(1'b1, 14'h3C00, 14'($urandom), 2, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_start_in_done();
    int          c, exp_on;
    logic [15:0] exp_sig;
    key_a = 14'($urandom); key_b = 14'($urandom) & 14'($urandom);
    do_sweep(1'b0, 14'h3FF0, 14'h1234, 3, 1'b0, 1'b1, "pre_done");
    fix_mask = 14'h3E0F; fix_val = 14'h2A5A; start0 = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (busy0 !== 1'b0 || x_valid0 !== 1'b0 || done0 !== 1'b0)
      $display("FAIL start_in_done_ignored: got busy=%b xv=%b done=%b want 0 0 0", busy0, x_valid0, done0);
    else n_pass++;
    @(posedge clk); #1;
    start0 = 1'b0;
    n_checks++;
    if (busy0 !== 1'b1 || x_valid0 !== 1'b1 || x0 !== m_scatter(14'h3E0F, 14'h2A5A, 0))
      $display("FAIL start_after_done: got busy=%b xv=%b x=%h want 1 1 %h", busy0, x_valid0, x0,
               m_scatter(14'h3E0F, 14'h2A5A, 0));
    else n_pass++;
    c = 0;
    while (done0 !== 1'b1 && c < 64) begin
      @(posedge clk); #1;
      c++;
    end
    model_run(14'h3E0F, 14'h2A5A, 3, 32, exp_on, exp_sig);
    $display("start in done: second sweep onset=%0d sig=%h", onset0, sig0);
    n_checks++;
    if (done0 !== 1'b1) $display("FAIL second_done: got %b want 1 within 64 cycles", done0);
    else n_pass++;
    n_checks++;
    if (onset0 !== 15'(exp_on) || sig0 !== exp_sig)
      $display("FAIL second_result: got onset=%0d sig=%h want onset=%0d sig=%h", onset0, sig0, exp_on, exp_sig);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [13:0] m;
    int          ft;
    for (int t = 0; t < 6; t++) begin
      m  = 14'h3FFF;
      ft = (t == 0) ? 0 : $urandom_range(1, 9);
      while ($countones(~m) < ft) m[$urandom_range(0, 13)] = 1'b0;
      key_a = 14'($urandom);
      key_b = 14'($urandom) & 14'($urandom) & 14'($urandom);
      do_sweep(1'($urandom_range(0, 1)), m, 14'($urandom), 3, 1'b0, 1'b0, "random");
    end
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    test_reset();
    test_full_xor();
    test_all_fixed();
    test_lat3();
    test_abort();
    test_reset_mid_drain();
    key_a = 14'($urandom); key_b = 14'($urandom) & 14'($urandom);
    do_sweep(1'b0, 14'h3F0F, 14'($urandom), 3, 1'b1, 1'b0, "start_abort_idle");
    test_start_in_done();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
